// File: rtl/alu_control_md_pkg.sv
// Shared constants for the ALU control decoder with the RV32M multiply/divide sequencer.
package alu_control_md_pkg;

    // Base ALU opcodes (bit 4 clear)
    localparam logic [4:0] ALU_AND   = 5'b00000;
    localparam logic [4:0] ALU_OR    = 5'b00001;
    localparam logic [4:0] ALU_SUM   = 5'b00010;
    localparam logic [4:0] ALU_EQUAL = 5'b00011;
    localparam logic [4:0] ALU_SLL   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_XOR   = 5'b01000;
    localparam logic [4:0] ALU_SUB   = 5'b01010;
    localparam logic [4:0] ALU_GE    = 5'b01100;
    localparam logic [4:0] ALU_GEU   = 5'b01101;
    localparam logic [4:0] ALU_SLT   = 5'b01110;
    localparam logic [4:0] ALU_SLTU  = 5'b01111;

    // M-extension opcodes: {2'b10, func3}
    localparam logic [4:0] MD_MUL    = 5'b10000;
    localparam logic [4:0] MD_MULH   = 5'b10001;
    localparam logic [4:0] MD_MULHSU = 5'b10010;
    localparam logic [4:0] MD_MULHU  = 5'b10011;
    localparam logic [4:0] MD_DIV    = 5'b10100;
    localparam logic [4:0] MD_DIVU   = 5'b10101;
    localparam logic [4:0] MD_REM    = 5'b10110;
    localparam logic [4:0] MD_REMU   = 5'b10111;

    // func3 values of the M operations
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_REM    = 3'd6;

    // Main-decoder operation classes
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;

    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/alu_control_md_iter_core.sv
// Iterative multiply/divide datapath: operand latch, iteration counter,
// shift-add multiplier and restoring divider on magnitudes, sign fixup.
module md_iter_core
    import alu_control_md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            run_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            fast_o,
    output logic [XLEN-1:0] fast_result_o,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);

    localparam int ITERS = XLEN / STEPS;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              a_neg, b_neg, signed_a, signed_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [2*XLEN-1:0] p_step, prod;
    logic [XLEN-1:0]   div_sel;

    // One shift-add step: {acc_hi, multiplier} shifts right, adding b when the low bit is set
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN:0] sum;
        sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        return {sum, p[XLEN-1:1]};
    endfunction

    // One restoring-division step: {remainder, quotient/dividend} shifts left
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        diff = sh - {1'b0, b};
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
        end
        return {sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
    endfunction

    // Operand signedness, magnitudes and fast-path detection from the live inputs
    always_comb begin
        signed_a = func3_i[2] ? !func3_i[0] : (func3_i == F3_MULH || func3_i == F3_MULHSU);
        signed_b = func3_i[2] ? !func3_i[0] : (func3_i == F3_MULH);
        a_neg    = signed_a & rs1_i[XLEN-1];
        b_neg    = signed_b & rs2_i[XLEN-1];
        mag_a    = a_neg ? -rs1_i : rs1_i;
        mag_b    = b_neg ? -rs2_i : rs2_i;
        div_zero = func3_i[2] && (rs2_i == '0);
        div_ovf  = (func3_i == F3_DIV || func3_i == F3_REM) &&
                   (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        fast_o   = div_zero | div_ovf;
        if (div_zero) begin
            fast_result_o = func3_i[1] ? rs1_i : '1;
        end else begin
            fast_result_o = func3_i[1] ? '0 : rs1_i;
        end
    end

    // STEPS iterations per cycle, then sign fixup on the final value
    always_comb begin
        p_step = p_q;
        for (int i = 0; i < STEPS; i++) begin
            p_step = op_q[2] ? div_step(p_step, b_q) : mul_step(p_step, b_q);
        end
        prod    = neg_q ? -p_step : p_step;
        div_sel = op_q[1] ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0];
        if (op_q[2]) begin
            result_o = neg_q ? -div_sel : div_sel;
        end else begin
            result_o = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        last_o = (cnt_q == CNT_W'(ITERS - 1));
    end

    // Next-state of the operand latch and iteration counter
    always_comb begin
        op_d  = op_q;
        b_d   = b_q;
        neg_d = neg_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (start_i) begin
            op_d  = func3_i;
            b_d   = mag_b;
            neg_d = (func3_i == F3_REM) ? a_neg : (a_neg ^ b_neg);
            p_d   = {{XLEN{1'b0}}, mag_a};
            cnt_d = '0;
        end else if (run_i) begin
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            b_q   <= b_d;
            neg_q <= neg_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: base/M opcode decode plus the multiply/divide sequencer FSM.
module alu_control_md
    import alu_control_md_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 5,
    parameter int STEPS    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic                flush_i,
    input  logic                is_immediate,
    input  logic [1:0]          aluop_in,
    input  logic [6:0]          func7,
    input  logic [2:0]          func3,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic [OP_WIDTH-1:0] aluop_out,
    output logic                md_op_o,
    output logic                stall_o,
    output logic                done_o,
    output logic [XLEN-1:0]     md_result_o
);

    md_state_e       state_q, state_d;
    logic [XLEN-1:0] md_result_q, md_result_d;
    logic            start, busy, run;
    logic            fast, last;
    logic [XLEN-1:0] fast_result, core_result;

    // Opcode decode; branches use inverted-sense compares (zero result means taken)
    always_comb begin
        aluop_out = ALU_SUM;
        md_op_o   = 1'b0;
        case (aluop_in)
            ALUOP_BRANCH: begin
                case (func3)
                    3'b000:  aluop_out = ALU_SUB;
                    3'b001:  aluop_out = ALU_EQUAL;
                    3'b100:  aluop_out = ALU_GE;
                    3'b101:  aluop_out = ALU_SLT;
                    3'b110:  aluop_out = ALU_GEU;
                    3'b111:  aluop_out = ALU_SLTU;
                    default: aluop_out = ALU_SUM;
                endcase
            end
            ALUOP_ARITH: begin
                if (!is_immediate && func7 == FUNC7_MULDIV) begin
                    md_op_o   = 1'b1;
                    aluop_out = {2'b10, func3};
                end else begin
                    case (func3)
                        3'b000:  aluop_out = (func7[5] && !is_immediate) ? ALU_SUB : ALU_SUM;
                        3'b001:  aluop_out = ALU_SLL;
                        3'b010:  aluop_out = ALU_SLT;
                        3'b011:  aluop_out = ALU_SLTU;
                        3'b100:  aluop_out = ALU_XOR;
                        3'b101:  aluop_out = func7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  aluop_out = ALU_OR;
                        default: aluop_out = ALU_AND;
                    endcase
                end
            end
            default: aluop_out = ALU_SUM;
        endcase
    end

    md_iter_core #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .run_i         (run),
        .func3_i       (func3),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .fast_o        (fast),
        .fast_result_o (fast_result),
        .last_o        (last),
        .result_o      (core_result)
    );

    // Handshake outputs; a start only happens from IDLE, so valid_i in DONE is ignored
    always_comb begin
        busy    = (state_q == ST_MUL) || (state_q == ST_DIV);
        start   = (state_q == ST_IDLE) && valid_i && md_op_o && !flush_i;
        run     = busy && !flush_i;
        stall_o = start || busy;
        done_o  = (state_q == ST_DONE);
    end

    // Next state and result capture; flush wins over both start and completion
    always_comb begin
        state_d     = state_q;
        md_result_d = md_result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (fast) begin
                            state_d     = ST_DONE;
                            md_result_d = fast_result;
                        end else begin
                            state_d = func3[2] ? ST_DIV : ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last) begin
                        state_d     = ST_DONE;
                        md_result_d = core_result;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            md_result_q <= md_result_d;
        end
    end

    assign md_result_o = md_result_q;

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes aluop/func3/func7 into a widened ALU opcode that adds RV32M operations.
- Owns an iterative multiply/divide sequencer with a stall handshake.
- Sits in EX: base ops drive the combinational ALU; M ops run here and return a result to EX writeback.

Parameters:
XLEN, 32, operand/result width; must be even and ≥8.
OP_WIDTH, 5, aluop_out width; fixed at 5 in this generation.
STEPS, 1, iteration bits retired per cycle (1, 2 or 4); must divide XLEN.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  decoded fields and operands are valid this cycle
flush_i  in  1  abort any in-flight M op
is_immediate  in  1  instruction is I-type
aluop_in  in  2  main-decoder class: 00 add, 01 branch, 10 arith
func7  in  7  instruction func7
func3  in  3  instruction func3
rs1_i  in  XLEN  operand A
rs2_i  in  XLEN  operand B
aluop_out  out  OP_WIDTH  ALU opcode, combinational
md_op_o  out  1  current decode is an M op, combinational
stall_o  out  1  hold upstream pipeline
done_o  out  1  one-cycle pulse; md_result_o valid
md_result_o  out  XLEN  M-op result, held until next start

Behaviour:
- Base decode: aluop_out[4]=0. aluop_out[3:0] uses the existing 4-bit ALU codes, unchanged.
  - AND 0000, OR 0001, SUM 0010, EQUAL 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111.
  - Branch and arith func3 mappings are identical to the current decoder.
  - Default SUM.
- M decode: aluop_in=10, is_immediate=0, func7=0000001 -> md_op_o=1 and aluop_out={2'b10,func3}.
  - func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - Start when valid_i & md_op_o & !flush_i: latch op, rs1, rs2.
  - stall_o=1 combinationally in the start cycle.
  - Next state is MUL, DIV, or DONE (fast path).
- MUL/DIV:
  - Run XLEN/STEPS cycles, shift-add / restoring on magnitudes; stall_o=1 throughout.
  - Signs are fixed in the final step.
  - MULH* return bits [2*XLEN-1:XLEN]; MUL returns the low half.
- DONE: stall_o=0, done_o=1, md_result_o valid. Next state is IDLE.
  - valid_i in DONE belongs to the completing instruction and never restarts the FSM.
- Latency: start edge k -> done_o high in cycle k+XLEN/STEPS+1 (33 cycles at defaults). Fast path gives done_o at k+1.
- Fast path (no iterations):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
  - Signed overflow (rs1=MIN, rs2=-1): DIV = MIN; REM = 0.
- flush_i: any state -> IDLE next edge, no done_o, md_result_o unchanged.
  - flush_i has priority over start and over completion.
- Reset (async, rst_n=0): state IDLE; stall_o, done_o=0; md_result_o=0; internal registers 0.
  - Reset mid-operation discards the op silently.
- Non-M decodes never touch the FSM. stall_o=0 in IDLE for non-M ops.

Decomposition:
- Shared package holds:
  - ALU opcode localparams (ALU_AND..ALU_SLTU, MD_MUL..MD_REMU);
  - FSM state encoding;
  - M-op func7 constant 0000001.
- One sub-module: md_iter_core. Operand latch, iteration counter, shift-add / restoring datapath, sign fixup.
- Top-level holds the decoder and FSM control.

Test Plan:
- Base decode sweep:
  - aluop_in=10, func3=000, func7=0100000, is_immediate=0 -> aluop_out=01010 (SUB).
  - Same fields with is_immediate=1 -> 00010 (SUM).
  - aluop_in=01, func3=101 -> 01110.
- MUL/MULHU: rs1=0xFFFFFFFF, rs2=0x00000002.
  - MUL -> 0xFFFFFFFE.
  - MULHU -> 0x00000001.
  - MULH -> 0xFFFFFFFF.
  - done_o 33 cycles after start; stall_o high for exactly 33 cycles.
- DIV/REM signed: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
- Corner cases:
  - DIVU rs2=0 -> 0xFFFFFFFF, done_o at k+1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Abort: flush_i pulsed at iteration 10 of DIV -> IDLE next edge, no done_o, md_result_o keeps prior value.
  - Repeat with rst_n low mid-MUL -> all outputs 0 immediately.
- Back-to-back: MUL then DIVU, valid_i held through DONE -> exactly one done_o per op, no spurious restart. Repeat with STEPS=4 -> latency 9 cycles.
